// File: rtl/hs32_sram_arbiter_if.sv
// Bus bundle for the HS32 SRAM arbiter: the management Wishbone slave,
// the CPU memory port and the 1RW SRAM macro port.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface hs32_sram_arbiter_if #(
  parameter int unsigned AW = 8
);
  // Wishbone slave side
  logic          wbs_cyc_i;
  logic          wbs_stb_i;
  logic          wbs_we_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_adr_i;
  logic [31:0]   wbs_dat_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;

  // CPU memory port
  logic          cpu_req;
  logic          cpu_we;
  logic [3:0]    cpu_mask;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_dtw;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [31:0]   cpu_dtr;

  // SRAM macro port
  logic          ram_csb;
  logic          ram_web;
  logic [3:0]    ram_wmask;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  cpu_req, cpu_we, cpu_mask, cpu_addr, cpu_dtw,
    output cpu_gnt, cpu_rvalid, cpu_dtr,
    output ram_csb, ram_web, ram_wmask, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output cpu_req, cpu_we, cpu_mask, cpu_addr, cpu_dtw,
    input  cpu_gnt, cpu_rvalid, cpu_dtr,
    input  ram_csb, ram_web, ram_wmask, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/hs32_sram_arbiter.sv
// Shares one 1RW port of a 32xN SRAM between the HS32 CPU memory port and
// the management Wishbone slave. CPU has priority; a starvation counter
// forces a Wishbone grant after STARVE_MAX consecutive lost contentions.
// Wishbone gets single-word classic cycles with a registered ack.
module hs32_sram_arbiter #(
  parameter int unsigned AW         = 8,
  parameter logic [31:0] WB_BASE    = 32'h3000_0000,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  hs32_sram_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RD   = 2'd1,
    W_ACK  = 2'd2
  } wb_state_t;

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  wb_state_t   r_state;
  wb_state_t   w_state_nxt;
  logic [3:0]  r_starve;
  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_rvalid;

  logic        w_wb_cyc;
  logic        w_wb_match;
  logic        w_wb_req;
  logic        w_wb_oor;
  logic        w_cpu_win;
  logic        w_wb_win;
  logic        w_starved;
  logic        w_unused_adr;

  // Byte-lane bits of the Wishbone address never reach the word-addressed SRAM.
  assign w_unused_adr = &{1'b0, bus.wbs_adr_i[1:0]};

  // Wishbone request qualification: only a fresh cycle in W_IDLE is eligible,
  // so an outstanding access or a raised ack can never be issued twice.
  always_comb begin
    w_wb_match = (bus.wbs_adr_i[31:AW+2] == WB_BASE[31:AW+2]);
    w_wb_cyc   = bus.wbs_cyc_i & bus.wbs_stb_i & (r_state == W_IDLE) & ~wb_rst_i;
    w_wb_req   = w_wb_cyc & w_wb_match;
    w_wb_oor   = w_wb_cyc & ~w_wb_match;
  end

  // Arbitration: CPU first unless the Wishbone side has waited STARVE_MAX grants.
  always_comb begin
    w_starved = (r_starve == LP_STARVE_MAX);
    w_cpu_win = bus.cpu_req & ~wb_rst_i & ~(w_wb_req & w_starved);
    w_wb_win  = w_wb_req & ~w_cpu_win;
  end

  // SRAM port mux; an idle port is deselected with all other lines at zero.
  always_comb begin
    bus.ram_csb   = 1'b1;
    bus.ram_web   = 1'b0;
    bus.ram_wmask = '0;
    bus.ram_addr  = '0;
    bus.ram_din   = '0;
    bus.cpu_gnt   = w_cpu_win;
    if (w_cpu_win) begin
      bus.ram_csb   = 1'b0;
      bus.ram_web   = ~bus.cpu_we;
      bus.ram_wmask = bus.cpu_we ? bus.cpu_mask : 4'h0;
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_din   = bus.cpu_dtw;
    end else if (w_wb_win) begin
      bus.ram_csb   = 1'b0;
      bus.ram_web   = ~bus.wbs_we_i;
      bus.ram_wmask = bus.wbs_we_i ? bus.wbs_sel_i : 4'h0;
      bus.ram_addr  = bus.wbs_adr_i[AW+1:2];
      bus.ram_din   = bus.wbs_dat_i;
    end
  end

  // Starvation counter: counts CPU wins over a waiting Wishbone request.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_starve <= '0;
    end else if (w_wb_win || !w_wb_req) begin
      r_starve <= '0;
    end else if (w_cpu_win && (r_starve < LP_STARVE_MAX)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // CPU read response strobe, one cycle after a granted read.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_cpu_win & ~bus.cpu_we;
    end
  end

  // Wishbone FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= W_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wishbone FSM next state: writes ack next cycle, reads go through W_RD
  // to pick up the SRAM data, out-of-range accesses ack without touching SRAM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      W_IDLE: begin
        if (w_wb_win) begin
          w_state_nxt = bus.wbs_we_i ? W_ACK : W_RD;
        end else if (w_wb_oor) begin
          w_state_nxt = W_ACK;
        end
      end
      W_RD:    w_state_nxt = W_ACK;
      W_ACK:   w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Registered ack, high for exactly the W_ACK cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= (w_state_nxt == W_ACK);
    end
  end

  // Read data register: SRAM data in W_RD, zero for an out-of-range access,
  // otherwise holds.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_dat <= '0;
    end else if (r_state == W_RD) begin
      r_dat <= bus.ram_dout;
    end else if (w_wb_oor) begin
      r_dat <= '0;
    end
  end

  // Output hookup.
  always_comb begin
    bus.wbs_ack_o  = r_ack;
    bus.wbs_dat_o  = r_dat;
    bus.cpu_rvalid = r_rvalid;
    bus.cpu_dtr    = bus.ram_dout;
  end

endmodule

// File: tb/tb_hs32_sram_arbiter.sv
// Directed bench for hs32_sram_arbiter with a behavioural 1RW SRAM model.
module tb_hs32_sram_arbiter;

  logic clk;
  logic rst;
  int unsigned total;
  int unsigned bad;

  hs32_sram_arbiter_if #(.AW(8)) bus ();

  hs32_sram_arbiter #(
    .AW(8),
    .WB_BASE(32'h3000_0000),
    .STARVE_MAX(4)
  ) u_dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: masked write, registered read data.
  logic [31:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  end
  always @(posedge clk) begin
    if (!bus.ram_csb) begin
      if (!bus.ram_web) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_wmask[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
      end else begin
        bus.ram_dout <= mem[bus.ram_addr];
      end
    end
  end

  task automatic idle();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_mask = 4'h0;
    bus.cpu_addr = 8'h0; bus.cpu_dtw = 32'h0;
  endtask

  task automatic wb_set(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel;
  endtask

  task automatic cpu_set(input logic we, input logic [7:0] addr, input logic [31:0] dat,
                         input logic [3:0] mask);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
    bus.cpu_dtw = dat; bus.cpu_mask = mask;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    cpu_set(1'b0, 8'h01, 32'h0, 4'h0);
    wb_set(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++; if (bus.cpu_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b exp=0", bus.cpu_gnt); end
      total++; if (bus.ram_csb !== 1'b1) begin bad++; $display("FAIL rst_csb got=%b exp=1", bus.ram_csb); end
      total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", bus.wbs_ack_o); end
      total++; if (bus.cpu_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", bus.cpu_rvalid); end
      total++; if (bus.wbs_dat_o !== 32'h0) begin bad++; $display("FAIL rst_dat got=%h exp=0", bus.wbs_dat_o); end
    end
    rst = 1'b0;
    idle();
    #1;
    total++; if (bus.ram_csb !== 1'b1 || bus.ram_addr !== 8'h0 || bus.ram_wmask !== 4'h0)
      begin bad++; $display("FAIL idle_port got csb=%b addr=%h wmask=%h exp csb=1 addr=0 wmask=0",
                            bus.ram_csb, bus.ram_addr, bus.ram_wmask); end
  endtask

  task automatic test_cpu_wr_rd();
    @(negedge clk);
    cpu_set(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF); #1;
    total++; if (bus.cpu_gnt !== 1'b1) begin bad++; $display("FAIL cpu_wr_gnt got=%b exp=1", bus.cpu_gnt); end
    total++; if ({bus.ram_csb, bus.ram_web, bus.ram_wmask, bus.ram_addr, bus.ram_din} !== {1'b0, 1'b0, 4'hF, 8'h10, 32'hDEAD_BEEF})
      begin bad++; $display("FAIL cpu_wr_drive got csb=%b web=%b wm=%h a=%h d=%h exp 0 0 f 10 deadbeef",
                            bus.ram_csb, bus.ram_web, bus.ram_wmask, bus.ram_addr, bus.ram_din); end
    @(negedge clk);
    cpu_set(1'b0, 8'h10, 32'h0, 4'hF); #1;
    total++; if (bus.cpu_rvalid !== 1'b0) begin bad++; $display("FAIL cpu_wr_norsp got=%b exp=0", bus.cpu_rvalid); end
    total++; if ({bus.cpu_gnt, bus.ram_web, bus.ram_wmask} !== {1'b1, 1'b1, 4'h0})
      begin bad++; $display("FAIL cpu_rd_drive got gnt=%b web=%b wm=%h exp 1 1 0", bus.cpu_gnt, bus.ram_web, bus.ram_wmask); end
    @(negedge clk);
    idle(); #1;
    total++; if (bus.cpu_rvalid !== 1'b1) begin bad++; $display("FAIL cpu_rvalid got=%b exp=1", bus.cpu_rvalid); end
    total++; if (bus.cpu_dtr !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cpu_dtr got=%h exp=deadbeef", bus.cpu_dtr); end
    @(negedge clk); #1;
    total++; if (bus.cpu_rvalid !== 1'b0) begin bad++; $display("FAIL cpu_rvalid_pulse got=%b exp=0", bus.cpu_rvalid); end
  endtask

  task automatic test_wb_byte();
    @(negedge clk);
    cpu_set(1'b1, 8'h10, 32'h0, 4'hF);
    @(negedge clk);
    idle();
    wb_set(1'b1, 32'h3000_0040, 32'h1122_3344, 4'b0010); #1;
    total++; if ({bus.ram_csb, bus.ram_web, bus.ram_wmask, bus.ram_addr, bus.ram_din} !== {1'b0, 1'b0, 4'h2, 8'h10, 32'h1122_3344})
      begin bad++; $display("FAIL wb_wr_drive got csb=%b web=%b wm=%h a=%h d=%h exp 0 0 2 10 11223344",
                            bus.ram_csb, bus.ram_web, bus.ram_wmask, bus.ram_addr, bus.ram_din); end
    total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL wb_wr_ack0 got=%b exp=0", bus.wbs_ack_o); end
    @(negedge clk); #1;
    total++; if (bus.wbs_ack_o !== 1'b1) begin bad++; $display("FAIL wb_wr_ack got=%b exp=1", bus.wbs_ack_o); end
    total++; if (bus.ram_csb !== 1'b1) begin bad++; $display("FAIL wb_wr_nodup got csb=%b exp=1", bus.ram_csb); end
    idle();
    @(negedge clk);
    wb_set(1'b0, 32'h3000_0040, 32'h0, 4'hF); #1;
    total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL wb_wr_ack_once got=%b exp=0", bus.wbs_ack_o); end
    total++; if ({bus.ram_csb, bus.ram_web, bus.ram_wmask, bus.ram_addr} !== {1'b0, 1'b1, 4'h0, 8'h10})
      begin bad++; $display("FAIL wb_rd_drive got csb=%b web=%b wm=%h a=%h exp 0 1 0 10",
                            bus.ram_csb, bus.ram_web, bus.ram_wmask, bus.ram_addr); end
    @(negedge clk); #1;
    total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL wb_rd_ack_n1 got=%b exp=0", bus.wbs_ack_o); end
    total++; if (bus.ram_csb !== 1'b1) begin bad++; $display("FAIL wb_rd_nodup got csb=%b exp=1", bus.ram_csb); end
    @(negedge clk); #1;
    total++; if (bus.wbs_ack_o !== 1'b1) begin bad++; $display("FAIL wb_rd_ack got=%b exp=1", bus.wbs_ack_o); end
    total++; if (bus.wbs_dat_o !== 32'h0000_3300) begin bad++; $display("FAIL wb_rd_dat got=%h exp=00003300", bus.wbs_dat_o); end
    idle();
    @(negedge clk); #1;
    total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL wb_rd_ack_once got=%b exp=0", bus.wbs_ack_o); end
    total++; if (bus.wbs_dat_o !== 32'h0000_3300) begin bad++; $display("FAIL wb_dat_hold got=%h exp=00003300", bus.wbs_dat_o); end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    cpu_set(1'b1, 8'h00, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cpu_set(1'b0, 8'h05, 32'h0, 4'h0);
      wb_set(1'b0, 32'h3000_0000, 32'h0, 4'hF); #1;
      total++; if (bus.cpu_gnt !== (i != 4)) begin bad++; $display("FAIL starve_gnt%0d got=%b exp=%b", i, bus.cpu_gnt, (i != 4)); end
      total++; if (bus.cpu_rvalid !== (i != 0)) begin bad++; $display("FAIL starve_rvalid%0d got=%b exp=%b", i, bus.cpu_rvalid, (i != 0)); end
      total++; if (bus.ram_addr !== ((i != 4) ? 8'h05 : 8'h00) || bus.ram_csb !== 1'b0)
        begin bad++; $display("FAIL starve_addr%0d got a=%h csb=%b exp a=%h csb=0", i, bus.ram_addr, bus.ram_csb, (i != 4) ? 8'h05 : 8'h00); end
    end
    @(negedge clk); #1;
    total++; if ({bus.cpu_gnt, bus.cpu_rvalid, bus.wbs_ack_o} !== 3'b100)
      begin bad++; $display("FAIL starve_wrd got gnt=%b rv=%b ack=%b exp 1 0 0", bus.cpu_gnt, bus.cpu_rvalid, bus.wbs_ack_o); end
    @(negedge clk); #1;
    total++; if (bus.wbs_ack_o !== 1'b1) begin bad++; $display("FAIL starve_ack got=%b exp=1", bus.wbs_ack_o); end
    total++; if (bus.wbs_dat_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL starve_dat got=%h exp=cafef00d", bus.wbs_dat_o); end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    wb_set(1'b0, 32'h3000_0000, 32'h0, 4'hF); #1;
    total++; if (bus.cpu_gnt !== 1'b1) begin bad++; $display("FAIL starve_clear got gnt=%b exp=1", bus.cpu_gnt); end
    idle();
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    wb_set(1'b0, 32'h2000_0000, 32'h0, 4'hF); #1;
    total++; if (bus.ram_csb !== 1'b1) begin bad++; $display("FAIL oor_csb got=%b exp=1", bus.ram_csb); end
    @(negedge clk); #1;
    total++; if (bus.wbs_ack_o !== 1'b1) begin bad++; $display("FAIL oor_ack got=%b exp=1", bus.wbs_ack_o); end
    total++; if (bus.wbs_dat_o !== 32'h0) begin bad++; $display("FAIL oor_dat got=%h exp=0", bus.wbs_dat_o); end
    idle();
    @(negedge clk); #1;
    total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL oor_ack_once got=%b exp=0", bus.wbs_ack_o); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    wb_set(1'b0, 32'h3000_0040, 32'h0, 4'hF); #1;
    total++; if (bus.ram_csb !== 1'b0) begin bad++; $display("FAIL rmr_grant got csb=%b exp=0", bus.ram_csb); end
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk); #1;
    total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL rmr_ack_r got=%b exp=0", bus.wbs_ack_o); end
    total++; if (bus.wbs_dat_o !== 32'h0) begin bad++; $display("FAIL rmr_dat_r got=%h exp=0", bus.wbs_dat_o); end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL rmr_noack%0d got=%b exp=0", i, bus.wbs_ack_o); end
    end
    wb_set(1'b0, 32'h3000_0040, 32'h0, 4'hF); #1;
    total++; if (bus.ram_csb !== 1'b0 || bus.ram_addr !== 8'h10)
      begin bad++; $display("FAIL rmr_regrant got csb=%b a=%h exp csb=0 a=10", bus.ram_csb, bus.ram_addr); end
    @(negedge clk); #1;
    total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL rmr_ack_n1 got=%b exp=0", bus.wbs_ack_o); end
    @(negedge clk); #1;
    total++; if (bus.wbs_ack_o !== 1'b1) begin bad++; $display("FAIL rmr_ack got=%b exp=1", bus.wbs_ack_o); end
    total++; if (bus.wbs_dat_o !== 32'h0000_3300) begin bad++; $display("FAIL rmr_dat got=%h exp=00003300", bus.wbs_dat_o); end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_cpu_wr_rd();
    test_wb_byte();
    test_starvation();
    test_out_of_range();
    test_reset_mid_read();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
